// File: rtl/sm_reg_trace.sv
// Debug trace capture: samples PC, instruction and one GPR per CPU step over the
// sm_top debug port, buffers records in a FIFO and streams them as 12-byte packets.
module sm_reg_trace #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned REG_SEL    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cpuStep,
  input  logic [31:0]                 instr,
  output logic [4:0]                  regAddr,
  input  logic [31:0]                 regData,
  output logic [7:0]                  outData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
  output logic                        overflow,
  input  logic                        clrOverflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAP_PC  = 2'd1;
  localparam logic [1:0] CAP_REG = 2'd2;
  localparam logic [1:0] PUSH    = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] ins;
    logic [31:0] gpr;
  } rec_t;

  // Packet byte at position idx; position 11 carries the XOR of bytes 1..10.
  function automatic logic [7:0] pkt_byte(input rec_t r, input logic [3:0] idx);
    logic [7:0] csum;
    csum = r.pc[15:8] ^ r.pc[7:0]
         ^ r.ins[31:24] ^ r.ins[23:16] ^ r.ins[15:8] ^ r.ins[7:0]
         ^ r.gpr[31:24] ^ r.gpr[23:16] ^ r.gpr[15:8] ^ r.gpr[7:0];
    case (idx)
      4'd0:    pkt_byte = 8'hA5;
      4'd1:    pkt_byte = r.pc[15:8];
      4'd2:    pkt_byte = r.pc[7:0];
      4'd3:    pkt_byte = r.ins[31:24];
      4'd4:    pkt_byte = r.ins[23:16];
      4'd5:    pkt_byte = r.ins[15:8];
      4'd6:    pkt_byte = r.ins[7:0];
      4'd7:    pkt_byte = r.gpr[31:24];
      4'd8:    pkt_byte = r.gpr[23:16];
      4'd9:    pkt_byte = r.gpr[15:8];
      4'd10:   pkt_byte = r.gpr[7:0];
      default: pkt_byte = csum;
    endcase
  endfunction

  logic [1:0]       cap_state_q, cap_state_d;
  logic [4:0]       reg_addr_q, reg_addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [15:0]      pc_q, pc_d;
  logic [31:0]      gpr_q, gpr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [0:0]       ser_state_q, ser_state_d;
  rec_t             hold_q, hold_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             push_c, drop_c, pop_c;
  rec_t             mem_q [FIFO_DEPTH];

  // Capture FSM: drives the debug select and builds one record per accepted step.
  always_comb begin
    cap_state_d = cap_state_q;
    reg_addr_d  = reg_addr_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    gpr_d       = gpr_q;
    push_c      = 1'b0;
    drop_c      = 1'b0;
    case (cap_state_q)
      IDLE: begin
        reg_addr_d = 5'd0;
        if (cpuStep && enable) begin
          instr_d     = instr;
          cap_state_d = CAP_PC;
        end
      end
      CAP_PC: begin
        pc_d        = regData[15:0];
        reg_addr_d  = 5'(REG_SEL);
        cap_state_d = CAP_REG;
      end
      CAP_REG: begin
        gpr_d       = regData;
        reg_addr_d  = 5'd0;
        cap_state_d = PUSH;
      end
      default: begin
        if (level_q < LVL_W'(FIFO_DEPTH)) push_c = 1'b1;
        else                              drop_c = 1'b1;
        cap_state_d = IDLE;
      end
    endcase
  end

  // Serializer FSM: pops a record and emits its 12 bytes, chaining packets when more are queued.
  always_comb begin
    ser_state_d = ser_state_q;
    hold_d      = hold_q;
    byte_idx_d  = byte_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pop_c       = 1'b0;
    case (ser_state_q)
      S_IDLE: pop_c = (level_q != '0);
      default: begin
        if (out_valid_q && outReady) begin
          if (byte_idx_q == 4'd11) begin
            pop_c = (level_q != '0);
            if (!pop_c) begin
              out_valid_d = 1'b0;
              ser_state_d = S_IDLE;
            end
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            out_data_d = pkt_byte(hold_q, byte_idx_q + 4'd1);
          end
        end
      end
    endcase
    if (pop_c) begin
      hold_d      = mem_q[rd_ptr_q];
      byte_idx_d  = 4'd0;
      out_valid_d = 1'b1;
      out_data_d  = 8'hA5;
      ser_state_d = S_SEND;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    ovf_d    = drop_c ? 1'b1 : (clrOverflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{pc: pc_q, ins: instr_q, gpr: gpr_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_state_q <= IDLE;
      reg_addr_q  <= 5'd0;
      instr_q     <= 32'd0;
      pc_q        <= 16'd0;
      gpr_q       <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      ser_state_q <= S_IDLE;
      hold_q      <= '0;
      byte_idx_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      cap_state_q <= cap_state_d;
      reg_addr_q  <= reg_addr_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      gpr_q       <= gpr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      ser_state_q <= ser_state_d;
      hold_q      <= hold_d;
      byte_idx_q  <= byte_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign regAddr   = reg_addr_q;
  assign outData   = out_data_q;
  assign outValid  = out_valid_q;
  assign fifoLevel = level_q;
  assign overflow  = ovf_q;

endmodule
